bcd_accumulator: RTL and testbench

Sequential BCD accumulator on the stage downstream of the two-digit switch-entry BCD adder. It accepts a two-digit BCD operand on a start strobe and adds it digit-serially into a running multi-digit BCD total. It flags invalid operand digits and sticky overflow. Its committed total drives the per-digit seven-segment decoders.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 31 +++
 rtl/bcd_accumulator.sv | 119 +++++++++++
 tb/tb_bcd_accumulator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD accumulator slice: FSM encoding, digit
// constants and an operand-digit validity helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BCD_W     = 4;
    localparam int BCD_MAX   = 9;
    localparam int BCD_RADIX = 10;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return int'(d) <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with carry in/out.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] s,
    output logic             cout
);

    localparam logic [BCD_W:0] MAX_V   = BCD_MAX[BCD_W:0];
    localparam logic [BCD_W:0] RADIX_V = BCD_RADIX[BCD_W:0];

    logic [BCD_W:0] t;
    logic [BCD_W:0] t_adj;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        t     = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        t_adj = t;
        cout  = 1'b0;
        if (t > MAX_V) begin
            t_adj = t - RADIX_V;
            cout  = 1'b1;
        end
        s = t_adj[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_accumulator.sv
// Digit-serial BCD accumulator: adds a two-digit BCD operand into a running
// ACC_DIGITS-digit total, one digit per cycle, with sticky overflow.
module bcd_accumulator
    import bcd_pkg::*;
#(
    parameter int ACC_DIGITS = 3
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic                        Clear,
    input  logic [7:0]                  A,
    output logic                        Ready,
    output logic                        Done,
    output logic [BCD_W*ACC_DIGITS-1:0] Sum,
    output logic                        Overflow,
    output logic                        Error
);

    localparam int               W        = BCD_W * ACC_DIGITS;
    localparam int               IDX_W    = $clog2(ACC_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_DIGITS - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     op;
    logic [W-1:0]     work;
    logic [W-1:0]     work_upd;

    logic [BCD_W-1:0] dig_a, dig_b, dig_s;
    logic             dig_cout;

    logic operand_ok, accept, reject, adding, last_digit;

    assign operand_ok = bcd_valid(A[3:0]) && bcd_valid(A[7:4]);
    assign accept     = (state == ST_IDLE) && Start && !Clear && operand_ok;
    assign reject     = (state == ST_IDLE) && Start && !Clear && !operand_ok;
    assign adding     = (state == ST_ADD) && !Clear;
    assign last_digit = adding && (idx == LAST_IDX);

    // One shared digit adder, steered to the current digit by the counter.
    assign dig_a = work[int'(idx)*BCD_W +: BCD_W];
    assign dig_b = op[int'(idx)*BCD_W +: BCD_W];

    bcd_digit_add u_digit_add (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry),
        .s    (dig_s),
        .cout (dig_cout)
    );

    always_comb begin
        work_upd = work;
        work_upd[int'(idx)*BCD_W +: BCD_W] = dig_s;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)               state_nxt = ST_ADD;
            ST_ADD:  if (idx == LAST_IDX)      state_nxt = ST_DONE;
            ST_DONE:                           state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
        if (Clear) state_nxt = ST_IDLE;
    end

    assign Ready = (state == ST_IDLE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx      <= '0;
            carry    <= 1'b0;
            op       <= '0;
            work     <= '0;
            Sum      <= '0;
            Overflow <= 1'b0;
            Error    <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Clear) begin
                Sum      <= '0;
                Overflow <= 1'b0;
                Error    <= 1'b0;
            end else begin
                if (reject) Error <= 1'b1;
                if (accept) begin
                    op    <= W'(A);
                    work  <= Sum;
                    idx   <= '0;
                    carry <= 1'b0;
                    Error <= 1'b0;
                end
                if (adding) begin
                    work  <= work_upd;
                    carry <= dig_cout;
                    idx   <= idx + IDX_W'(1);
                end
                // Commit on the edge that enters DONE so Sum never shows a partial total.
                if (last_digit) begin
                    Sum      <= work_upd;
                    Overflow <= Overflow | dig_cout;
                    Done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_accumulator.sv
// Directed, table-driven bench for bcd_accumulator (ACC_DIGITS = 3).
module tb_bcd_accumulator;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Clear;
    logic [7:0]  A;
    logic        Ready;
    logic        Done;
    logic [11:0] Sum;
    logic        Overflow;
    logic        Error;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_accumulator #(.ACC_DIGITS(3)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Clear    (Clear),
        .A        (A),
        .Ready    (Ready),
        .Done     (Done),
        .Sum      (Sum),
        .Overflow (Overflow),
        .Error    (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0]  a;
        logic        valid;
        logic [11:0] sum;
        logic        ovf;
        logic        err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one Start pulse and watch the following 8 cycles.
    task automatic do_add(input string tag, input logic [7:0] a, input logic valid,
                          input logic exp_err);
        int done_at;
        int done_cnt;
        logic ready_after;
        @(negedge Clock);
        Start = 1'b1;
        A     = a;
        @(negedge Clock);
        Start = 1'b0;
        check({tag, " err_timing"}, 32'(Error), 32'(exp_err));
        check({tag, " ready_after_start"}, 32'(Ready), 32'(!valid));
        done_at     = -1;
        done_cnt    = 0;
        ready_after = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            if (Done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == 4) ready_after = Ready;
        end
        check({tag, " done_count"}, 32'(done_cnt), valid ? 32'd1 : 32'd0);
        if (valid) begin
            check({tag, " done_latency"}, 32'(done_at), 32'd3);
            check({tag, " ready_after_done"}, 32'(ready_after), 32'd1);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int done_cnt;

        vecs[0] = '{8'h47, 1'b1, 12'h047, 1'b0, 1'b0};
        vecs[1] = '{8'h58, 1'b1, 12'h105, 1'b0, 1'b0};
        vecs[2] = '{8'h3A, 1'b0, 12'h105, 1'b0, 1'b1};
        vecs[3] = '{8'h94, 1'b1, 12'h199, 1'b0, 1'b0};
        vecs[4] = '{8'h99, 1'b1, 12'h298, 1'b0, 1'b0};
        vecs[5] = '{8'hF0, 1'b0, 12'h298, 1'b0, 1'b1};
        vecs[6] = '{8'h01, 1'b1, 12'h299, 1'b0, 1'b0};

        Reset = 1'b1;
        Start = 1'b0;
        Clear = 1'b0;
        A     = 8'h00;
        repeat (2) @(negedge Clock);
        check("reset sum",   32'(Sum),      32'h000);
        check("reset ready", 32'(Ready),    32'd1);
        check("reset done",  32'(Done),     32'd0);
        check("reset ovf",   32'(Overflow), 32'd0);
        check("reset err",   32'(Error),    32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].valid, vecs[i].err);
            check($sformatf("vec%0d sum", i), 32'(Sum),      32'(vecs[i].sum));
            check($sformatf("vec%0d ovf", i), 32'(Overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d err", i), 32'(Error),    32'(vecs[i].err));
        end

        // Build 999 and wrap past it.
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        check("clear sum", 32'(Sum), 32'h000);
        for (int i = 0; i < 10; i++) do_add("add99", 8'h99, 1'b1, 1'b0);
        do_add("add09", 8'h09, 1'b1, 1'b0);
        check("999 sum", 32'(Sum),      32'h999);
        check("999 ovf", 32'(Overflow), 32'd0);
        do_add("wrap", 8'h01, 1'b1, 1'b0);
        check("wrap sum", 32'(Sum),      32'h000);
        check("wrap ovf", 32'(Overflow), 32'd1);
        do_add("post", 8'h02, 1'b1, 1'b0);
        check("post sum", 32'(Sum),      32'h002);
        check("post ovf", 32'(Overflow), 32'd1);

        // Asynchronous reset between edges in the middle of an add.
        @(negedge Clock);
        Start = 1'b1;
        A     = 8'h33;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        check("async sum",   32'(Sum),      32'h000);
        check("async ovf",   32'(Overflow), 32'd0);
        check("async ready", 32'(Ready),    32'd1);
        check("async done",  32'(Done),     32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            if (Done) done_cnt++;
        end
        check("async no_done", 32'(done_cnt), 32'd0);

        // Clear sampled at edge k+2 aborts the add; Start held into ADD is ignored.
        do_add("pre55", 8'h55, 1'b1, 1'b0);
        check("pre55 sum", 32'(Sum), 32'h055);
        @(negedge Clock);
        Start = 1'b1;
        A     = 8'h11;
        @(negedge Clock);
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        Start = 1'b0;
        check("abort sum",   32'(Sum),   32'h000);
        check("abort ready", 32'(Ready), 32'd1);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            if (Done) done_cnt++;
        end
        check("abort no_done", 32'(done_cnt), 32'd0);

        // Start held for an extra edge during ADD must not add twice.
        @(negedge Clock);
        Start = 1'b1;
        A     = 8'h11;
        @(negedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clock);
            if (Done) done_cnt++;
        end
        check("held done_count", 32'(done_cnt), 32'd1);
        check("held sum",        32'(Sum),      32'h011);

        // Start and Clear together in IDLE: Clear wins, no add.
        @(negedge Clock);
        Start = 1'b1;
        Clear = 1'b1;
        A     = 8'h22;
        @(negedge Clock);
        Start = 1'b0;
        Clear = 1'b0;
        check("both sum",   32'(Sum),   32'h000);
        check("both ready", 32'(Ready), 32'd1);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            if (Done) done_cnt++;
        end
        check("both no_done", 32'(done_cnt), 32'd0);
        check("both sum_end", 32'(Sum),      32'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
